timer_min_sec_up: RTL and testbench
===================================

TIMER_MIN_SEC_UP -- requirements
Module: timer_min_sec_up

Interface
REQ-001 Parameter: MIN_TENS_MOD, default 6, modulus of the minute-tens digit (legal values 2..8).
REQ-002 clk  input  1  rising-edge clock.
REQ-003 clearn  input  1  asynchronous active-low reset/clear.
REQ-004 loadn  input  1  synchronous active-low preset load.
REQ-005 en  input  1  count tick, one clk wide, 1 Hz nominal.
REQ-006 data  input  14  preset, packed {min_tens[2:0], min_ones[3:0], sec_tens[2:0], sec_ones[3:0]}.
REQ-007 sec_ones  output  4  seconds units digit, BCD 0..9.
REQ-008 sec_tens  output  3  seconds tens digit, 0..5.
REQ-009 min_ones  output  4  minutes units digit, 0..9.
REQ-010 min_tens  output  3  minutes tens digit, 0..MIN_TENS_MOD-1.
REQ-011 tc  output  1  terminal count; combinational.
REQ-012 zero  output  1  high when all digits are 0; combinational.

Function
REQ-013 Counting is upward; digits cascade sec_ones(mod 10) -> sec_tens(mod 6) -> min_ones(mod 10) -> min_tens(MIN_TENS_MOD).
REQ-014 With loadn=1 and en=1, the count shall advance by exactly one second on that rising edge; a digit increments only when all lower digits are at their maximum, and each maximum digit wraps to 0.
REQ-015 Priority on a rising edge: loadn=0 (load) over en=1 (count); en=0 with loadn=1 holds all digits.
REQ-016 Load shall take effect on the same edge, with one-cycle latency to the outputs, independent of en.
REQ-017 A loaded digit above its maximum (ones>9, sec_tens>5, min_tens>MIN_TENS_MOD-1) shall load as 0; other digits load unchanged.
REQ-018 tc = en AND (count == maximum, e.g. 59:59 for default); tc shall never be asserted while en=0.
REQ-019 Without the configuration macro, the edge after tc wraps the count to 00:00.
REQ-020 zero shall depend only on the registered digits, not on en or loadn.

Reset
REQ-021 clearn=0 shall, asynchronously and without waiting for clk, force all digits to 0 (zero=1, tc=0).
REQ-022 clearn shall override loadn and en for as long as it is held low; counting resumes on the first en edge after release.
REQ-023 Reset asserted mid-count shall leave no partial carry; the next count after release is 00:01.

Configuration
REQ-024 Macro TIMER_MIN_SEC_UP_SATURATE_EN: when defined, the count shall stick at the maximum (e.g. 59:59) and ignore further en ticks until load or clear; tc shall still pulse with each en tick while at maximum.
REQ-025 Without TIMER_MIN_SEC_UP_SATURATE_EN, wrap-around per REQ-019 applies.

Structure
REQ-026 A shared package/header shall hold the digit-maximum constants (9, 5), the data field offsets/widths, and the default of MIN_TENS_MOD.
REQ-027 One sub-module, digit_up_counter (parameter MOD, WIDTH; ports clk, clearn, loadn, en, data, q, tc), shall be instantiated four times; its tc = en AND q==MOD-1.
REQ-028 The en input of each higher digit shall be the tc of the digit below it; loads are not gated by the cascade.

Verification
REQ-029 clearn=0 pulse between clock edges -> all digits 0 immediately, zero=1, tc=0.
REQ-030 Load data=00:58, en=1 for 3 ticks -> 00:59, 01:00, 01:01; tc=0 throughout.
REQ-031 Load 59:59, en=1 -> tc=1 in that cycle; next edge gives 00:00 (default) or holds 59:59 (SATURATE_EN).
REQ-032 Load sec_ones=12, sec_tens=7, min_ones=3, min_tens=2 -> outputs 23:00.
REQ-033 loadn=0 and en=1 on the same edge with data=10:20 -> 10:20, not 10:21; en=0 for 5 cycles -> count unchanged, tc=0.
REQ-034 Count to 00:07, then assert clearn for 1 ns, then en=1 -> 00:00 followed by 00:01.

Source files
------------

// File: rtl/timer_min_sec_up_pkg.sv
// Shared constants for the mm:ss up-counter: digit limits and preset field layout.
// Latency: n/a (constants only).
// Backpressure: n/a.
package timer_min_sec_up_pkg;

   // Largest legal value of each fixed-modulus digit
   localparam int SEC_ONES_MAX = 9;
   localparam int SEC_TENS_MAX = 5;
   localparam int MIN_ONES_MAX = 9;

   // Default modulus of the minute-tens digit (counts 00:00 .. 59:59)
   localparam int MIN_TENS_MOD_DEFAULT = 6;

   // Preset word layout: {min_tens[2:0], min_ones[3:0], sec_tens[2:0], sec_ones[3:0]}
   localparam int DATA_W       = 14;
   localparam int SEC_ONES_LSB = 0;
   localparam int SEC_ONES_W   = 4;
   localparam int SEC_TENS_LSB = 4;
   localparam int SEC_TENS_W   = 3;
   localparam int MIN_ONES_LSB = 7;
   localparam int MIN_ONES_W   = 4;
   localparam int MIN_TENS_LSB = 11;
   localparam int MIN_TENS_W   = 3;

endpackage

// File: rtl/timer_min_sec_up_digit_up_counter.sv
// One modulo-MOD up-counting digit with synchronous clamped load and carry-out.
// Latency: load/increment visible one clk after the edge; tc is combinational.
// Backpressure: none; en is a single-cycle tick, load wins over en.
//
// Ports: clk, clearn (async active-low clear), loadn (sync active-low load),
//        en (increment tick), data (preset), q (digit value),
//        tc (en AND q == MOD-1, used as the next digit's en).
module digit_up_counter #(
   parameter int MOD   = 10,
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             clearn,
   input  logic             loadn,
   input  logic             en,
   input  logic [WIDTH-1:0] data,
   output logic [WIDTH-1:0] q,
   output logic             tc
);

   localparam logic [WIDTH-1:0] MAXV = WIDTH'(MOD - 1);

   always_ff @(posedge clk or negedge clearn) begin
      if (!clearn) begin
         q <= '0;
      end else if (!loadn) begin
         // Out-of-range presets would leave the digit in an unreachable state
         q <= (data > MAXV) ? '0 : data;
      end else if (en) begin
         q <= (q == MAXV) ? '0 : q + WIDTH'(1);
      end
   end

   assign tc = en && (q == MAXV);

endmodule

// File: rtl/timer_min_sec_up.sv
// Minutes:seconds BCD up-counter (mm:ss) built from four cascaded digit counters.
// Latency: one clk from load/en edge to digit outputs; tc and zero are combinational.
// Backpressure: none; every en tick is counted (or ignored at max when saturating).
//
// Ports: clk, clearn (async active-low clear), loadn (sync active-low preset),
//        en (1 Hz count tick), data (packed preset), sec_ones/sec_tens/min_ones/
//        min_tens (digits), tc (en AND count at maximum), zero (all digits 0).
// Build option: define TIMER_MIN_SEC_UP_SATURATE_EN to hold at the maximum count
//               instead of wrapping to 00:00.
module timer_min_sec_up
   import timer_min_sec_up_pkg::*;
#(
   parameter int MIN_TENS_MOD = MIN_TENS_MOD_DEFAULT
) (
   input  logic              clk,
   input  logic              clearn,
   input  logic              loadn,
   input  logic              en,
   input  logic [DATA_W-1:0] data,
   output logic [3:0]        sec_ones,
   output logic [2:0]        sec_tens,
   output logic [3:0]        min_ones,
   output logic [2:0]        min_tens,
   output logic              tc,
   output logic              zero
);

   logic count_en;
   logic so_tc;
   logic st_tc;
   logic mo_tc;
   logic mt_tc;

`ifdef TIMER_MIN_SEC_UP_SATURATE_EN
   logic at_max;
   assign at_max = (sec_ones == 4'(SEC_ONES_MAX)) &&
                   (sec_tens == 3'(SEC_TENS_MAX)) &&
                   (min_ones == 4'(MIN_ONES_MAX)) &&
                   (min_tens == 3'(MIN_TENS_MOD - 1));
   // Ticks are swallowed at the maximum so the chain never wraps; the chain's
   // own carry is then always 0 at max, so tc is rebuilt from en directly.
   assign count_en = en && !at_max;
   assign tc       = mt_tc || (en && at_max);
`else
   assign count_en = en;
   assign tc       = mt_tc;
`endif

   digit_up_counter #(.MOD(SEC_ONES_MAX + 1), .WIDTH(SEC_ONES_W)) u_sec_ones (
      .clk    (clk),
      .clearn (clearn),
      .loadn  (loadn),
      .en     (count_en),
      .data   (data[SEC_ONES_LSB +: SEC_ONES_W]),
      .q      (sec_ones),
      .tc     (so_tc)
   );

   digit_up_counter #(.MOD(SEC_TENS_MAX + 1), .WIDTH(SEC_TENS_W)) u_sec_tens (
      .clk    (clk),
      .clearn (clearn),
      .loadn  (loadn),
      .en     (so_tc),
      .data   (data[SEC_TENS_LSB +: SEC_TENS_W]),
      .q      (sec_tens),
      .tc     (st_tc)
   );

   digit_up_counter #(.MOD(MIN_ONES_MAX + 1), .WIDTH(MIN_ONES_W)) u_min_ones (
      .clk    (clk),
      .clearn (clearn),
      .loadn  (loadn),
      .en     (st_tc),
      .data   (data[MIN_ONES_LSB +: MIN_ONES_W]),
      .q      (min_ones),
      .tc     (mo_tc)
   );

   digit_up_counter #(.MOD(MIN_TENS_MOD), .WIDTH(MIN_TENS_W)) u_min_tens (
      .clk    (clk),
      .clearn (clearn),
      .loadn  (loadn),
      .en     (mo_tc),
      .data   (data[MIN_TENS_LSB +: MIN_TENS_W]),
      .q      (min_tens),
      .tc     (mt_tc)
   );

   assign zero = (sec_ones == 4'd0) && (sec_tens == 3'd0) &&
                 (min_ones == 4'd0) && (min_tens == 3'd0);

endmodule

// File: tb/tb_timer_min_sec_up.sv
// Self-checking bench: directed scenarios with literal expectations plus a
// randomized run compared every cycle against a seconds-count model.
module tb_timer_min_sec_up;

   localparam int MT     = 6;
   localparam int MAXCNT = MT * 600 - 1;

   logic        clk = 1'b0;
   logic        clearn = 1'b0;
   logic        loadn = 1'b1;
   logic        en = 1'b0;
   logic [13:0] data = '0;
   logic [3:0]  sec_ones;
   logic [2:0]  sec_tens;
   logic [3:0]  min_ones;
   logic [2:0]  min_tens;
   logic        tc;
   logic        zero;

   int n_checks = 0;
   int n_fail   = 0;
   int cnt      = 0;   // model: elapsed seconds, 0..MAXCNT

   timer_min_sec_up #(.MIN_TENS_MOD(MT)) dut (
      .clk      (clk),
      .clearn   (clearn),
      .loadn    (loadn),
      .en       (en),
      .data     (data),
      .sec_ones (sec_ones),
      .sec_tens (sec_tens),
      .min_ones (min_ones),
      .min_tens (min_tens),
      .tc       (tc),
      .zero     (zero)
   );

   always #5 clk = ~clk;

   function automatic logic [13:0] pack(input logic [2:0] mt, input logic [3:0] mo,
                                        input logic [2:0] st, input logic [3:0] so);
      return {mt, mo, st, so};
   endfunction

   // Preset word -> seconds, with out-of-range digits treated as 0
   function automatic int decode(input logic [13:0] d);
      int so, st, mo, mt;
      so = (d[3:0]   > 9)      ? 0 : int'(d[3:0]);
      st = (d[6:4]   > 5)      ? 0 : int'(d[6:4]);
      mo = (d[10:7]  > 9)      ? 0 : int'(d[10:7]);
      mt = (int'(d[13:11]) > MT - 1) ? 0 : int'(d[13:11]);
      return mt * 600 + mo * 60 + st * 10 + so;
   endfunction

   always @(negedge clearn) cnt = 0;

   always @(posedge clk) begin
      if (clearn) begin
         if (!loadn) cnt = decode(data);
         else if (en) begin
            if (cnt == MAXCNT) begin
`ifdef TIMER_MIN_SEC_UP_SATURATE_EN
               cnt = MAXCNT;
`else
               cnt = 0;
`endif
            end else begin
               cnt = cnt + 1;
            end
         end
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
      end
   endtask

   // Every-cycle comparison against the model
   always @(negedge clk) begin
      chk("model_sec_ones", int'(sec_ones), cnt % 10);
      chk("model_sec_tens", int'(sec_tens), (cnt / 10) % 6);
      chk("model_min_ones", int'(min_ones), (cnt / 60) % 10);
      chk("model_min_tens", int'(min_tens), cnt / 600);
      chk("model_tc",       int'(tc),   (en && cnt == MAXCNT) ? 1 : 0);
      chk("model_zero",     int'(zero), (cnt == 0) ? 1 : 0);
   end

   task automatic expect_time(input string name, input int mt, input int mo,
                              input int st, input int so);
      chk({name, "_min_tens"}, int'(min_tens), mt);
      chk({name, "_min_ones"}, int'(min_ones), mo);
      chk({name, "_sec_tens"}, int'(sec_tens), st);
      chk({name, "_sec_ones"}, int'(sec_ones), so);
   endtask

   // Apply inputs, let them settle, then take one rising edge
   task automatic step(input logic l, input logic e, input logic [13:0] d);
      loadn = l;
      en    = e;
      data  = d;
      @(posedge clk);
      #1;
   endtask

   task automatic clear_pulse();
      clearn = 1'b0;
      #1;
      clearn = 1'b1;
   endtask

   initial begin
      // Reset state
      #3;
      expect_time("reset", 0, 0, 0, 0);
      chk("reset_zero", int'(zero), 1);
      chk("reset_tc", int'(tc), 0);
      @(posedge clk);
      #1;
      clearn = 1'b1;

      // 00:58 then three ticks
      step(1'b0, 1'b0, pack(3'd0, 4'd0, 3'd5, 4'd8));
      expect_time("load0058", 0, 0, 5, 8);
      en = 1'b1; loadn = 1'b1;
      #1 chk("tc_0058", int'(tc), 0);
      step(1'b1, 1'b1, data);
      expect_time("tick0059", 0, 0, 5, 9);
      chk("tc_0059", int'(tc), 0);
      step(1'b1, 1'b1, data);
      expect_time("tick0100", 0, 1, 0, 0);
      step(1'b1, 1'b1, data);
      expect_time("tick0101", 0, 1, 0, 1);
      chk("zero_0101", int'(zero), 0);

      // Max count: tc with en, then async clear between edges
      step(1'b0, 1'b0, pack(3'(MT - 1), 4'd9, 3'd5, 4'd9));
      chk("tc_max_en0", int'(tc), 0);
      en = 1'b1;
      #1 chk("tc_max_en1", int'(tc), 1);
      clearn = 1'b0;
      #1;
      expect_time("async_clr", 0, 0, 0, 0);
      chk("async_clr_zero", int'(zero), 1);
      chk("async_clr_tc", int'(tc), 0);
      clearn = 1'b1;
      @(posedge clk);
      #1;

      // Max count then one tick: wrap or hold
      step(1'b0, 1'b0, pack(3'(MT - 1), 4'd9, 3'd5, 4'd9));
      en = 1'b1;
      #1 chk("tc_max", int'(tc), 1);
      step(1'b1, 1'b1, data);
`ifdef TIMER_MIN_SEC_UP_SATURATE_EN
      expect_time("sat_hold", MT - 1, 9, 5, 9);
      chk("sat_tc_again", int'(tc), 1);
      step(1'b1, 1'b1, data);
      expect_time("sat_hold2", MT - 1, 9, 5, 9);
`else
      expect_time("wrap", 0, 0, 0, 0);
      chk("wrap_zero", int'(zero), 1);
`endif

      // Out-of-range preset digits load as 0
      step(1'b0, 1'b0, pack(3'd2, 4'd3, 3'd7, 4'd12));
      expect_time("clamp", 2, 3, 0, 0);

      // Load wins over en on the same edge, then hold
      step(1'b0, 1'b1, pack(3'd1, 4'd0, 3'd2, 4'd0));
      expect_time("load_pri", 1, 0, 2, 0);
      for (int i = 0; i < 5; i++) begin
         step(1'b1, 1'b0, data);
         expect_time("hold", 1, 0, 2, 0);
         chk("hold_tc", int'(tc), 0);
      end

      // Count to 00:07, clear, resume
      step(1'b0, 1'b0, pack(3'd0, 4'd0, 3'd0, 4'd6));
      step(1'b1, 1'b1, data);
      expect_time("at0007", 0, 0, 0, 7);
      en = 1'b0;
      clear_pulse();
      expect_time("clr0007", 0, 0, 0, 0);
      step(1'b1, 1'b1, data);
      expect_time("resume0001", 0, 0, 0, 1);

      // Randomized run, checked every cycle by the model comparison
      for (int i = 0; i < 3000; i++) begin
         int r;
         logic [13:0] d;
         r = int'($urandom_range(0, 99));
         if (r < 2) clear_pulse();
         d = (r >= 2 && r < 6) ? pack(3'(MT - 1), 4'd9, 3'd5, 4'($urandom_range(0, 9)))
                               : 14'($urandom);
         step((r >= 2 && r < 12) ? 1'b0 : 1'b1,
              ($urandom_range(0, 9) < 8) ? 1'b1 : 1'b0, d);
      end

      step(1'b1, 1'b0, '0);
      @(negedge clk);
      #1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
